// File: rtl/rf_write_sequencer_pkg.sv
// Shared widths and enumerations for the register-file write sequencer.
package rf_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 16;

  typedef enum logic {SWEEP = 1'b0, RUN = 1'b1} state_e;
  typedef enum logic {GNT_A = 1'b0, GNT_B = 1'b1} grant_e;

endpackage

// File: rtl/rf_write_sequencer_if.sv
// Two write requesters plus the registered register-file write port.
interface rf_write_sequencer_if #(
  parameter int ADDR_W = rf_pkg::ADDR_W,
  parameter int DATA_W = rf_pkg::DATA_W,
  parameter int CNT_W  = rf_pkg::CNT_W
);
  logic              a_valid;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_data;
  logic              a_ready;
  logic              b_valid;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_data;
  logic              b_ready;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_w_data;
  logic              init_done;
  logic [CNT_W-1:0]  wr_count;

  modport slave (
    input  a_valid, a_addr, a_data, b_valid, b_addr, b_data,
    output a_ready, b_ready, rd_addr, rd_w_data, init_done, wr_count
  );

  modport master (
    output a_valid, a_addr, a_data, b_valid, b_addr, b_data,
    input  a_ready, b_ready, rd_addr, rd_w_data, init_done, wr_count
  );
endinterface

// File: rtl/rf_write_sequencer_rr_arbiter2.sv
// Two-way round-robin arbiter; on a tie the requester not granted last wins.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);
  import rf_pkg::grant_e;
  import rf_pkg::GNT_A;
  import rf_pkg::GNT_B;

  grant_e last_grant_q;

  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = (last_grant_q == GNT_B) ? 2'b01 : 2'b10;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          last_grant_q <= GNT_B;
    else if (advance) last_grant_q <= gnt[0] ? GNT_A : GNT_B;
  end

endmodule

// File: rtl/rf_write_sequencer.sv
// Clears the register file after reset, then serialises writes from two requesters.
module rf_write_sequencer #(
  parameter int ADDR_W = rf_pkg::ADDR_W,
  parameter int DATA_W = rf_pkg::DATA_W,
  parameter int CNT_W  = rf_pkg::CNT_W
) (
  input logic reloj_cucu,
  input logic reseteate,
  rf_write_sequencer_if.slave bus
);
  import rf_pkg::SWEEP;
  import rf_pkg::RUN;

  localparam logic [0:0] ST_SWEEP = SWEEP;
  localparam logic [0:0] ST_RUN   = RUN;

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] sweep_ptr_q, sweep_ptr_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              init_done_q, init_done_d;
  logic [CNT_W-1:0]  wr_count_q, wr_count_d;

  logic [1:0]        req, gnt;
  logic              xfer;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

  // Requests are masked while sweeping so neither side sees ready.
  assign req  = {bus.b_valid, bus.a_valid} & {2{state_q == ST_RUN}};
  assign xfer = |gnt;

  rr_arbiter2 u_arb (
    .clk     (reloj_cucu),
    .rst     (reseteate),
    .req     (req),
    .advance (xfer),
    .gnt     (gnt)
  );

  assign sel_addr = gnt[0] ? bus.a_addr : bus.b_addr;
  assign sel_data = gnt[0] ? bus.a_data : bus.b_data;

  always_comb begin
    state_d     = state_q;
    sweep_ptr_d = sweep_ptr_q;
    rd_addr_d   = '0;
    rd_data_d   = '0;
    init_done_d = init_done_q;
    wr_count_d  = wr_count_q;
    if (state_q == ST_SWEEP) begin
      rd_addr_d   = sweep_ptr_q;
      sweep_ptr_d = sweep_ptr_q + ADDR_W'(1);
      if (sweep_ptr_q == '1) begin
        state_d     = ST_RUN;
        init_done_d = 1'b1;
      end
    end else if (xfer && sel_addr != '0) begin
      // Address-0 writes are accepted but leave the port idle.
      rd_addr_d  = sel_addr;
      rd_data_d  = sel_data;
      wr_count_d = wr_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge reloj_cucu or posedge reseteate) begin
    if (reseteate) begin
      state_q     <= ST_SWEEP;
      sweep_ptr_q <= ADDR_W'(1);
      rd_addr_q   <= '0;
      rd_data_q   <= '0;
      init_done_q <= 1'b0;
      wr_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      sweep_ptr_q <= sweep_ptr_d;
      rd_addr_q   <= rd_addr_d;
      rd_data_q   <= rd_data_d;
      init_done_q <= init_done_d;
      wr_count_q  <= wr_count_d;
    end
  end

  assign bus.a_ready   = gnt[0];
  assign bus.b_ready   = gnt[1];
  assign bus.rd_addr   = rd_addr_q;
  assign bus.rd_w_data = rd_data_q;
  assign bus.init_done = init_done_q;
  assign bus.wr_count  = wr_count_q;

endmodule

// File: tb/tb_rf_write_sequencer.sv
// Randomised bench for rf_write_sequencer with a behavioural arbitration/counter model.
module tb_rf_write_sequencer;
  logic reloj_cucu;
  logic reseteate;

  rf_write_sequencer_if bus ();

  rf_write_sequencer dut (
    .reloj_cucu (reloj_cucu),
    .reseteate  (reseteate),
    .bus        (bus)
  );

  int checks = 0;
  int errors = 0;
  int exp_cnt;
  bit last_was_b;

  initial begin
    reloj_cucu = 1'b0;
    forever #5 reloj_cucu = ~reloj_cucu;
  end

  task automatic cycle;
    @(posedge reloj_cucu);
    @(negedge reloj_cucu);
  endtask

  task automatic idle_inputs;
    bus.a_valid = 0; bus.a_addr = '0; bus.a_data = '0;
    bus.b_valid = 0; bus.b_addr = '0; bus.b_data = '0;
  endtask

  task automatic apply_reset;
    @(negedge reloj_cucu);
    reseteate = 1;
    idle_inputs();
    cycle();
    reseteate = 0;
    exp_cnt = 0;
    last_was_b = 1;
  endtask

  task automatic wait_init;
    int n = 0;
    while (bus.init_done !== 1'b1 && n < 40) begin cycle(); n++; end
    checks++;
    if (bus.init_done !== 1'b1) begin
      errors++; $display("FAIL init_timeout got init_done=%0b want 1", bus.init_done);
    end
    cycle();
  endtask

  task automatic test_reset;
    reseteate = 1;
    bus.a_valid = 1; bus.a_addr = 5'd7; bus.a_data = 32'h1;
    bus.b_valid = 1; bus.b_addr = 5'd8; bus.b_data = 32'h2;
    @(negedge reloj_cucu); #1;
    checks++;
    if ({bus.rd_addr, bus.rd_w_data, bus.init_done, bus.a_ready, bus.b_ready, bus.wr_count} !== '0) begin
      errors++;
      $display("FAIL reset_state got addr=%0d data=%h done=%0b ar=%0b br=%0b cnt=%0d want all zero",
               bus.rd_addr, bus.rd_w_data, bus.init_done, bus.a_ready, bus.b_ready, bus.wr_count);
    end
    idle_inputs();
  endtask

  task automatic test_sweep;
    int bad = 0;
    @(negedge reloj_cucu);
    reseteate = 0;
    exp_cnt = 0; last_was_b = 1;
    bus.a_valid = 1; bus.a_addr = 5'd9; bus.b_valid = 1; bus.b_addr = 5'd10;
    for (int k = 1; k <= 31; k++) begin
      #1;
      if (bus.a_ready !== 1'b0 || bus.b_ready !== 1'b0) bad++;
      cycle();
      checks++;
      if (bus.rd_addr !== 5'(k) || bus.rd_w_data !== '0 || bus.init_done !== (k == 31)) begin
        errors++;
        $display("FAIL sweep_step got addr=%0d data=%h done=%0b want addr=%0d data=0 done=%0b",
                 bus.rd_addr, bus.rd_w_data, bus.init_done, k, k == 31);
      end
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL sweep_ready got %0d ready cycles want 0", bad); end
    idle_inputs();
    cycle();
    checks++;
    if (bus.rd_addr !== '0 || bus.rd_w_data !== '0 || bus.init_done !== 1'b1 || bus.wr_count !== '0) begin
      errors++;
      $display("FAIL sweep_end got addr=%0d data=%h done=%0b cnt=%0d want 0 0 1 0",
               bus.rd_addr, bus.rd_w_data, bus.init_done, bus.wr_count);
    end
  endtask

  task automatic test_single_a;
    bus.a_valid = 1; bus.a_addr = 5'd5; bus.a_data = 32'hDEADBEEF;
    #1;
    checks++;
    if (bus.a_ready !== 1'b1 || bus.b_ready !== 1'b0) begin
      errors++; $display("FAIL single_a_ready got a=%0b b=%0b want 1 0", bus.a_ready, bus.b_ready);
    end
    exp_cnt = (exp_cnt + 1) & 16'hFFFF; last_was_b = 0;
    cycle();
    idle_inputs();
    checks++;
    if (bus.rd_addr !== 5'd5 || bus.rd_w_data !== 32'hDEADBEEF || bus.wr_count !== 16'(exp_cnt)) begin
      errors++;
      $display("FAIL single_a_out got addr=%0d data=%h cnt=%0d want 5 deadbeef %0d",
               bus.rd_addr, bus.rd_w_data, bus.wr_count, exp_cnt);
    end
  endtask

  task automatic test_addr0_b;
    bus.b_valid = 1; bus.b_addr = 5'd0; bus.b_data = 32'hFFFFFFFF;
    #1;
    checks++;
    if (bus.b_ready !== 1'b1) begin errors++; $display("FAIL addr0_ready got %0b want 1", bus.b_ready); end
    last_was_b = 1;
    cycle();
    idle_inputs();
    checks++;
    if (bus.rd_addr !== '0 || bus.rd_w_data !== '0 || bus.wr_count !== 16'(exp_cnt)) begin
      errors++;
      $display("FAIL addr0_out got addr=%0d data=%h cnt=%0d want 0 0 %0d",
               bus.rd_addr, bus.rd_w_data, bus.wr_count, exp_cnt);
    end
  endtask

  task automatic test_tie;
    bus.a_valid = 1; bus.a_addr = 5'd3; bus.a_data = 32'h11;
    bus.b_valid = 1; bus.b_addr = 5'd4; bus.b_data = 32'h22;
    #1;
    checks++;
    if (bus.a_ready !== 1'b1 || bus.b_ready !== 1'b0) begin
      errors++; $display("FAIL tie_first got a=%0b b=%0b want 1 0", bus.a_ready, bus.b_ready);
    end
    cycle();
    bus.a_valid = 0;
    checks++;
    if (bus.rd_addr !== 5'd3 || bus.rd_w_data !== 32'h11) begin
      errors++; $display("FAIL tie_out_a got addr=%0d data=%h want 3 11", bus.rd_addr, bus.rd_w_data);
    end
    #1;
    checks++;
    if (bus.b_ready !== 1'b1) begin errors++; $display("FAIL tie_second got b=%0b want 1", bus.b_ready); end
    cycle();
    idle_inputs();
    exp_cnt = (exp_cnt + 2) & 16'hFFFF; last_was_b = 1;
    checks++;
    if (bus.rd_addr !== 5'd4 || bus.rd_w_data !== 32'h22 || bus.wr_count !== 16'(exp_cnt)) begin
      errors++;
      $display("FAIL tie_out_b got addr=%0d data=%h cnt=%0d want 4 22 %0d",
               bus.rd_addr, bus.rd_w_data, bus.wr_count, exp_cnt);
    end
    cycle();
    checks++;
    if (bus.rd_addr !== '0 || bus.rd_w_data !== '0) begin
      errors++; $display("FAIL tie_idle got addr=%0d data=%h want 0 0", bus.rd_addr, bus.rd_w_data);
    end
  endtask

  task automatic test_random;
    bit ga, gb;
    logic [4:0]  ea;
    logic [31:0] ed;
    for (int n = 0; n < 300; n++) begin
      // A losing requester keeps its request; otherwise draw a fresh one.
      if (!bus.a_valid) begin
        bus.a_valid = ($urandom_range(0, 9) < 6);
        bus.a_addr  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        bus.a_data  = $urandom;
      end
      if (!bus.b_valid) begin
        bus.b_valid = ($urandom_range(0, 9) < 6);
        bus.b_addr  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        bus.b_data  = $urandom;
      end
      ga = bus.a_valid && (!bus.b_valid || last_was_b);
      gb = bus.b_valid && !ga;
      ea = '0; ed = '0;
      if (ga) begin ea = bus.a_addr; ed = bus.a_data; last_was_b = 0; end
      if (gb) begin ea = bus.b_addr; ed = bus.b_data; last_was_b = 1; end
      if (ea == 0) ed = '0;
      else exp_cnt = (exp_cnt + 1) & 16'hFFFF;
      #1;
      checks++;
      if (bus.a_ready !== ga || bus.b_ready !== gb) begin
        errors++;
        $display("FAIL rand_ready n=%0d got a=%0b b=%0b want %0b %0b", n, bus.a_ready, bus.b_ready, ga, gb);
      end
      cycle();
      checks++;
      if (bus.rd_addr !== ea || bus.rd_w_data !== ed || bus.wr_count !== 16'(exp_cnt)) begin
        errors++;
        $display("FAIL rand_out n=%0d got addr=%0d data=%h cnt=%0d want %0d %h %0d",
                 n, bus.rd_addr, bus.rd_w_data, bus.wr_count, ea, ed, exp_cnt);
      end
      if (ga) bus.a_valid = 0;
      if (gb) bus.b_valid = 0;
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid_sweep;
    int n = 0;
    apply_reset();
    while (bus.rd_addr !== 5'd12 && n < 40) begin cycle(); n++; end
    checks++;
    if (bus.rd_addr !== 5'd12) begin
      errors++; $display("FAIL midreset_reach got addr=%0d want 12", bus.rd_addr);
    end
    #2 reseteate = 1;
    #1;
    checks++;
    if (bus.rd_addr !== '0 || bus.rd_w_data !== '0 || bus.init_done !== 1'b0 || bus.wr_count !== '0) begin
      errors++;
      $display("FAIL midreset_async got addr=%0d data=%h done=%0b cnt=%0d want 0 0 0 0",
               bus.rd_addr, bus.rd_w_data, bus.init_done, bus.wr_count);
    end
    @(negedge reloj_cucu);
    reseteate = 0;
    cycle();
    checks++;
    if (bus.rd_addr !== 5'd1 || bus.init_done !== 1'b0) begin
      errors++; $display("FAIL midreset_restart got addr=%0d want 1", bus.rd_addr);
    end
    cycle();
    checks++;
    if (bus.rd_addr !== 5'd2) begin
      errors++; $display("FAIL midreset_step got addr=%0d want 2", bus.rd_addr);
    end
  endtask

  task automatic test_wrap;
    int bad = 0;
    apply_reset();
    wait_init();
    bus.a_valid = 1;
    for (int n = 0; n < 65535; n++) begin
      bus.a_addr = 5'($urandom_range(1, 31));
      bus.a_data = $urandom;
      #1;
      if (bus.a_ready !== 1'b1) bad++;
      cycle();
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL wrap_ready got %0d stalls want 0", bad); end
    checks++;
    if (bus.wr_count !== 16'hFFFF) begin
      errors++; $display("FAIL wrap_full got cnt=%h want ffff", bus.wr_count);
    end
    bus.a_addr = 5'd17; bus.a_data = 32'hCAFE0001;
    cycle();
    idle_inputs();
    checks++;
    if (bus.wr_count !== 16'h0000 || bus.rd_addr !== 5'd17 || bus.rd_w_data !== 32'hCAFE0001) begin
      errors++;
      $display("FAIL wrap_zero got cnt=%h addr=%0d data=%h want 0000 17 cafe0001",
               bus.wr_count, bus.rd_addr, bus.rd_w_data);
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_sweep();
    test_single_a();
    test_addr0_b();
    test_tie();
    test_random();
    test_reset_mid_sweep();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
